// File: rtl/dice_roll_controller_if.sv
// Bundles the roll handshake, random-source handshake and display outputs of
// dice_roll_controller. The master side is the controller itself.
interface dice_roll_controller_if;
    logic       roll;
    logic       rand_req;
    logic       rand_ack;
    logic [2:0] rand_val;
    logic       busy;
    logic       player;
    logic [2:0] die1;
    logic [2:0] die2;
    logic       done;
    logic [1:0] an;
    logic [3:0] digit;

    modport master (
        input  roll, rand_ack, rand_val,
        output rand_req, busy, player, die1, die2, done, an, digit
    );

    modport slave (
        output roll, rand_ack, rand_val,
        input  rand_req, busy, player, die1, die2, done, an, digit
    );
endinterface

// File: rtl/dice_roll_controller.sv
// Two-player dice roll sequencer. It shares one random source between the players,
// runs a timed tumble per roll, then latches the final value and passes the turn.
// It also multiplexes both digits onto one segment driver, with blanking at each
// slot change.
module dice_roll_controller #(
    parameter int TUMBLE_STEP_CYC = 6_250_000,
    parameter int TUMBLE_STEPS    = 12,
    parameter int REFRESH_CYC     = 62_500,
    parameter int BLANK_CYC       = 1_250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dice_roll_controller_if.master bus
);
    localparam int GAP_W  = (TUMBLE_STEP_CYC > 1) ? $clog2(TUMBLE_STEP_CYC) : 1;
    localparam int STEP_W = $clog2(TUMBLE_STEPS + 1);
    localparam int REF_W  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, GAP} state_t;

    state_t              state_reg;
    logic [STEP_W-1:0]   step_cnt_reg;
    logic [STEP_W-1:0]   step_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg;
    logic [2:0]          tumble_val_reg;
    logic [2:0]          die_reg [2];
    logic                player_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                rand_req_reg;
    logic                rand_ok;

    logic [REF_W-1:0]    slot_cnt_reg;
    logic [REF_W-1:0]    slot_cnt_next;
    logic                slot_reg;
    logic                slot_next;
    logic                blank_next;
    logic [1:0]          an_reg;
    logic [3:0]          digit_reg;
    logic [2:0]          shown_val [2];

    // Values 0 and 7 are not die faces and are thrown away by the tumble.
    assign rand_ok       = (bus.rand_val != 3'd0) && (bus.rand_val != 3'd7);
    assign step_cnt_next = step_cnt_reg + 1'b1;

    // Roll sequencer. The request and the result outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            step_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            tumble_val_reg <= '0;
            die_reg[0]     <= '0;
            die_reg[1]     <= '0;
            player_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rand_req_reg   <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            rand_req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.roll) begin
                        state_reg      <= REQ;
                        busy_reg       <= 1'b1;
                        step_cnt_reg   <= '0;
                        tumble_val_reg <= '0;
                        rand_req_reg   <= 1'b1;
                    end
                end
                REQ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (bus.rand_ack) begin
                        if (rand_ok) begin
                            tumble_val_reg <= bus.rand_val;
                            step_cnt_reg   <= step_cnt_next;
                            if (step_cnt_next == STEP_W'(TUMBLE_STEPS)) begin
                                die_reg[player_reg] <= bus.rand_val;
                                done_reg            <= 1'b1;
                                player_reg          <= ~player_reg;
                                busy_reg            <= 1'b0;
                                state_reg           <= IDLE;
                            end else begin
                                gap_cnt_reg <= '0;
                                state_reg   <= GAP;
                            end
                        end else begin
                            // Re-request immediately; the bad value is not a step.
                            rand_req_reg <= 1'b1;
                            state_reg    <= REQ;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == GAP_W'(TUMBLE_STEP_CYC - 1)) begin
                        rand_req_reg <= 1'b1;
                        state_reg    <= REQ;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The player being rolled shows the tumble value; the other shows its final die.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_shown
            assign shown_val[gi] = (busy_reg && (player_reg == 1'(gi))) ? tumble_val_reg
                                                                       : die_reg[gi];
        end
    endgenerate

    // Next slot position. The slot toggles when the counter wraps.
    always_comb begin
        slot_cnt_next = slot_cnt_reg + 1'b1;
        slot_next     = slot_reg;
        if (slot_cnt_reg == REF_W'(REFRESH_CYC - 1)) begin
            slot_cnt_next = '0;
            slot_next     = ~slot_reg;
        end
    end

    assign blank_next = (slot_cnt_next < REF_W'(BLANK_CYC));

    // Display scheduler. The digit is loaded only while the anodes are off, so it
    // never changes under a lit digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_reg <= '0;
            slot_reg     <= 1'b0;
            an_reg       <= 2'b00;
            digit_reg    <= 4'd0;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
            slot_reg     <= slot_next;
            an_reg       <= blank_next ? 2'b00 : (slot_next ? 2'b10 : 2'b01);
            if (blank_next) begin
                digit_reg <= {1'b0, shown_val[slot_next]};
            end
        end
    end

    assign bus.rand_req = rand_req_reg;
    assign bus.busy     = busy_reg;
    assign bus.player   = player_reg;
    assign bus.die1     = die_reg[0];
    assign bus.die2     = die_reg[1];
    assign bus.done     = done_reg;
    assign bus.an       = an_reg;
    assign bus.digit    = digit_reg;
endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller using small timing parameters.
module tb_dice_roll_controller;
    localparam int STEP_CYC = 4;
    localparam int STEPS    = 3;
    localparam int REF_CYC  = 8;
    localparam int BLANK    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dice_roll_controller_if bus();

    dice_roll_controller #(
        .TUMBLE_STEP_CYC(STEP_CYC),
        .TUMBLE_STEPS   (STEPS),
        .REFRESH_CYC    (REF_CYC),
        .BLANK_CYC      (BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [2:0] vals [8];
    int         req_cnt;
    int         req_cyc [16];
    int         done_cnt;
    int         done_cyc;
    logic [2:0] snap_die1;
    logic [2:0] snap_die2;
    logic       snap_player;
    logic       snap_busy;
    int         win_cnt;
    logic [3:0] win_dig [8];

    // Drives one roll starting at the current falling edge (cycle 0) and acts as
    // the random source, acking dly cycles after each request. Records events.
    task automatic do_roll(input int nvals, input int dly, input int xr1, input int xr2,
                           input int stop_at);
        int         ack_at;
        int         vi;
        logic [1:0] prev_an;
        logic       stop;
        req_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
        win_cnt  = 0;
        vi       = 0;
        ack_at   = -1;
        stop     = 1'b0;
        prev_an  = bus.an;
        bus.roll     = 1'b1;
        bus.rand_ack = 1'b0;
        for (int k = 1; k <= 400 && !stop; k++) begin
            @(negedge clk);
            if (stop_at >= 0 && k == stop_at) begin
                stop = 1'b1;
            end else begin
                if (bus.rand_req) begin
                    if (req_cnt < 16) req_cyc[req_cnt] = k;
                    req_cnt++;
                    ack_at = k + dly;
                end
                if (bus.done) begin
                    done_cnt++;
                    if (done_cyc < 0) begin
                        done_cyc    = k;
                        snap_die1   = bus.die1;
                        snap_die2   = bus.die2;
                        snap_player = bus.player;
                        snap_busy   = bus.busy;
                    end
                end
                if (bus.an == 2'b10 && prev_an == 2'b00 && bus.busy && win_cnt < 8) begin
                    win_dig[win_cnt] = bus.digit;
                    win_cnt++;
                end
                prev_an  = bus.an;
                bus.roll = (k == xr1) || (k == xr2);
                if (k == ack_at) begin
                    bus.rand_ack = 1'b1;
                    bus.rand_val = (vi < nvals) ? vals[vi] : 3'd1;
                    vi++;
                end else begin
                    bus.rand_ack = 1'b0;
                    bus.rand_val = 3'd0;
                end
                if (done_cyc >= 0 && k >= done_cyc + 4) stop = 1'b1;
            end
        end
        bus.roll     = 1'b0;
        bus.rand_ack = 1'b0;
        bus.rand_val = 3'd0;
        $display("roll: reqs=%0d dones=%0d done_cycle=%0d die1=%0d die2=%0d player=%0d",
                 req_cnt, done_cnt, done_cyc, bus.die1, bus.die2, bus.player);
    endtask

    task automatic test_reset();
        int         m;
        logic [1:0] exp_an;
        bus.roll     = 1'b0;
        bus.rand_ack = 1'b0;
        bus.rand_val = 3'd0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rand_req !== 1'b0 || bus.an !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b req=%b an=%b, expected 0 0 0 00",
                     bus.busy, bus.done, bus.rand_req, bus.an);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            m = i % 16;
            exp_an = (m < 2) ? 2'b00 : (m < 8) ? 2'b01 : (m < 10) ? 2'b00 : 2'b10;
            checks++;
            if (bus.an !== exp_an) begin
                errors++;
                $display("FAIL idle_an cycle %0d: got %b expected %b", i, bus.an, exp_an);
            end
            checks++;
            if (bus.digit !== 4'd0) begin
                errors++;
                $display("FAIL idle_digit cycle %0d: got %0d expected 0", i, bus.digit);
            end
        end
        checks++;
        if (bus.die1 !== 3'd0 || bus.die2 !== 3'd0 || bus.player !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: die1=%0d die2=%0d player=%b busy=%b, expected 0 0 0 0",
                     bus.die1, bus.die2, bus.player, bus.busy);
        end
        $display("reset: idle display pattern observed for 32 cycles");
    endtask

    task automatic test_single_roll();
        vals[0] = 3'd2; vals[1] = 3'd5; vals[2] = 3'd4;
        do_roll(3, 1, -1, -1, -1);
        checks++;
        if (req_cnt !== 3) begin
            errors++; $display("FAIL single_req_count: got %0d expected 3", req_cnt);
        end
        checks++;
        if (req_cyc[0] !== 1 || req_cyc[1] !== 7 || req_cyc[2] !== 13) begin
            errors++;
            $display("FAIL single_req_spacing: got %0d,%0d,%0d expected 1,7,13",
                     req_cyc[0], req_cyc[1], req_cyc[2]);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 15) begin
            errors++;
            $display("FAIL single_done: count=%0d cycle=%0d expected count 1 cycle 15",
                     done_cnt, done_cyc);
        end
        checks++;
        if (snap_die1 !== 3'd4 || snap_die2 !== 3'd0 || snap_player !== 1'b1 || snap_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_result: die1=%0d die2=%0d player=%b busy=%b expected 4 0 1 0",
                     snap_die1, snap_die2, snap_player, snap_busy);
        end
    endtask

    task automatic test_turn_alternation();
        logic [1:0] prev;
        prev = bus.an;
        // Start the roll on the first lit cycle of the J1 slot so the J2 slots fall
        // at known points of the tumble.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.an == 2'b01 && prev == 2'b00) break;
            prev = bus.an;
        end
        vals[0] = 3'd1; vals[1] = 3'd1; vals[2] = 3'd6;
        do_roll(3, 10, -1, -1, -1);
        checks++;
        if (done_cnt !== 1 || done_cyc !== 42) begin
            errors++;
            $display("FAIL turn_done: count=%0d cycle=%0d expected count 1 cycle 42",
                     done_cnt, done_cyc);
        end
        checks++;
        if (snap_die1 !== 3'd4 || snap_die2 !== 3'd6 || snap_player !== 1'b0) begin
            errors++;
            $display("FAIL turn_result: die1=%0d die2=%0d player=%b expected 4 6 0",
                     snap_die1, snap_die2, snap_player);
        end
        checks++;
        if (win_cnt !== 3) begin
            errors++; $display("FAIL tumble_windows: got %0d expected 3", win_cnt);
        end else begin
            checks++;
            if (win_dig[0] !== 4'd0 || win_dig[1] !== 4'd1 || win_dig[2] !== 4'd1) begin
                errors++;
                $display("FAIL tumble_digits: got %0d,%0d,%0d expected 0,1,1",
                         win_dig[0], win_dig[1], win_dig[2]);
            end
        end
    endtask

    task automatic test_invalid_value();
        vals[0] = 3'd0; vals[1] = 3'd3; vals[2] = 3'd7; vals[3] = 3'd2; vals[4] = 3'd5;
        do_roll(5, 1, -1, -1, -1);
        checks++;
        if (req_cnt !== 5) begin
            errors++; $display("FAIL invalid_req_count: got %0d expected 5", req_cnt);
        end
        checks++;
        if (req_cyc[0] !== 1 || req_cyc[1] !== 3 || req_cyc[2] !== 9 || req_cyc[3] !== 11 ||
            req_cyc[4] !== 17) begin
            errors++;
            $display("FAIL invalid_req_cycles: got %0d,%0d,%0d,%0d,%0d expected 1,3,9,11,17",
                     req_cyc[0], req_cyc[1], req_cyc[2], req_cyc[3], req_cyc[4]);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 19 || snap_die1 !== 3'd5 || snap_die2 !== 3'd6 ||
            snap_player !== 1'b1) begin
            errors++;
            $display("FAIL invalid_result: dones=%0d cycle=%0d die1=%0d die2=%0d player=%b expected 1 19 5 6 1",
                     done_cnt, done_cyc, snap_die1, snap_die2, snap_player);
        end
    endtask

    task automatic test_roll_while_busy();
        vals[0] = 3'd3; vals[1] = 3'd2; vals[2] = 3'd1;
        do_roll(3, 1, 2, 4, -1);
        checks++;
        if (req_cnt !== 3 || req_cyc[0] !== 1 || req_cyc[1] !== 7 || req_cyc[2] !== 13) begin
            errors++;
            $display("FAIL busy_reqs: count=%0d at %0d,%0d,%0d expected 3 at 1,7,13",
                     req_cnt, req_cyc[0], req_cyc[1], req_cyc[2]);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 15) begin
            errors++;
            $display("FAIL busy_done: count=%0d cycle=%0d expected count 1 cycle 15",
                     done_cnt, done_cyc);
        end
        checks++;
        if (snap_die2 !== 3'd1 || snap_die1 !== 3'd5 || snap_player !== 1'b0) begin
            errors++;
            $display("FAIL busy_result: die1=%0d die2=%0d player=%b expected 5 1 0",
                     snap_die1, snap_die2, snap_player);
        end
    endtask

    task automatic test_reset_mid_roll();
        logic saw_done;
        vals[0] = 3'd2; vals[1] = 3'd3; vals[2] = 3'd4;
        do_roll(3, 1, -1, -1, 10);
        checks++;
        if (bus.busy !== 1'b1 || req_cnt !== 2) begin
            errors++;
            $display("FAIL midroll_pre: busy=%b reqs=%0d expected 1 2", bus.busy, req_cnt);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.die1 !== 3'd0 || bus.die2 !== 3'd0 || bus.player !== 1'b0 ||
            bus.an !== 2'b00 || bus.digit !== 4'd0 || bus.done !== 1'b0 || bus.rand_req !== 1'b0) begin
            errors++;
            $display("FAIL midroll_async: busy=%b die1=%0d die2=%0d player=%b an=%b digit=%0d done=%b req=%b expected all 0",
                     bus.busy, bus.die1, bus.die2, bus.player, bus.an, bus.digit, bus.done, bus.rand_req);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL midroll_no_done: got activity=1 expected 0");
        end
        vals[0] = 3'd6; vals[1] = 3'd6; vals[2] = 3'd3;
        do_roll(3, 1, -1, -1, -1);
        checks++;
        if (done_cnt !== 1 || done_cyc !== 15 || snap_die1 !== 3'd3 || snap_die2 !== 3'd0 ||
            snap_player !== 1'b1) begin
            errors++;
            $display("FAIL midroll_fresh: dones=%0d cycle=%0d die1=%0d die2=%0d player=%b expected 1 15 3 0 1",
                     done_cnt, done_cyc, snap_die1, snap_die2, snap_player);
        end
    endtask

    initial begin
        test_reset();
        test_single_roll();
        test_turn_alternation();
        test_invalid_value();
        test_roll_while_busy();
        test_reset_mid_roll();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
